gpio_dbus_arb: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single GPIO peripheral slave port between several data-bus requesters (core LSU on port 0, debug/DMA master on port 1). It sits between the peripheral address decoders and `gpio`. It latches one granted transaction, drives it to the GPIO slave until ack, and returns the response to the owning requester. A timeout guards against a hung slave.

---
 rtl/gpio_dbus_arb_pkg.sv | 32 +++
 rtl/gpio_dbus_arb_rr_pick.sv | 27 ++
 rtl/gpio_dbus_arb.sv | 140 ++++++++++++++
 tb/tb_gpio_dbus_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_dbus_arb_pkg.sv
// Shared types and constants for the GPIO data-bus arbiter.
package gpio_dbus_arb_pkg;

  localparam int unsigned GPIO_ARB_NUM_REQ   = 2;
  localparam logic [31:0] GPIO_ARB_ERR_RDATA = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;

  // Transaction fields held stable towards the slave for the whole grant.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
  } type_gpio_arb_hold_s;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RESP
  } type_gpio_arb_states_e;

endpackage

// File: rtl/gpio_dbus_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module gpio_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpio_dbus_arb.sv
// Round-robin arbiter sharing the GPIO slave port between data-bus requesters,
// with one latched transaction in flight and a hung-slave timeout.
module gpio_dbus_arb
  import gpio_dbus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = GPIO_ARB_NUM_REQ,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic            [NUM_REQ-1:0]   req_sel_i,
  input  type_dbus2peri_s [NUM_REQ-1:0]   dbus2arb_i,
  output type_peri2dbus_s [NUM_REQ-1:0]   arb2dbus_o,
  output logic            [NUM_REQ-1:0]   arb_err_o,
  output logic                            gpio_sel_o,
  output type_dbus2peri_s                 arb2gpio_o,
  input  type_peri2dbus_s                 gpio2arb_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  type_gpio_arb_states_e state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         grant_idx_q, grant_idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  type_gpio_arb_hold_s   hold_q, hold_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mask_q, mask_d;

  logic [NUM_REQ-1:0]    act;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;

  // The just-served requester is hidden for one IDLE cycle so a late req drop
  // after its ack does not start a duplicate transaction.
  always_comb begin
    act = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      act[i] = req_sel_i[i] & dbus2arb_i[i].req
             & ~(mask_q & (grant_idx_q == IW'(i)));
    end
  end

  gpio_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (act),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mask_d      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_idx_d   = pick_idx;
          hold_d.addr   = dbus2arb_i[pick_idx].addr;
          hold_d.w_data = dbus2arb_i[pick_idx].w_data;
          hold_d.w_en   = dbus2arb_i[pick_idx].w_en;
          cnt_d         = '0;
          state_d       = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (gpio2arb_i.ack) begin
          rdata_d = gpio2arb_i.r_data;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_VAL)) begin
          rdata_d = GPIO_ARB_ERR_RDATA;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ARB_RESP: begin
        rr_ptr_d = (grant_idx_q == IW'(NUM_REQ - 1)) ? '0 : grant_idx_q + IW'(1);
        mask_d   = 1'b1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mask_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mask_q      <= mask_d;
    end
  end

  always_comb begin
    gpio_sel_o = 1'b0;
    arb2gpio_o = '0;
    arb2dbus_o = '0;
    arb_err_o  = '0;
    if (state_q == ARB_GRANT) begin
      gpio_sel_o        = 1'b1;
      arb2gpio_o.addr   = hold_q.addr;
      arb2gpio_o.w_data = hold_q.w_data;
      arb2gpio_o.w_en   = hold_q.w_en;
      arb2gpio_o.req    = 1'b1;
    end
    if (state_q == ARB_RESP) begin
      arb2dbus_o[grant_idx_q].r_data = rdata_q;
      arb2dbus_o[grant_idx_q].ack    = 1'b1;
      arb_err_o[grant_idx_q]         = err_q;
    end
  end

endmodule

// File: tb/tb_gpio_dbus_arb.sv
// Directed bench for gpio_dbus_arb with a registered-ack GPIO slave model.
module tb_gpio_dbus_arb;
  import gpio_dbus_arb_pkg::*;

  localparam logic [31:0] DATA_A = 32'h4000_0000;
  localparam logic [31:0] DIR_A  = 32'h4000_0004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: standard slave, default timeout
  logic            [1:0] sel_a;
  type_dbus2peri_s [1:0] bus_a;
  type_peri2dbus_s [1:0] rsp_a;
  logic            [1:0] err_a;
  logic                  gsel_a;
  type_dbus2peri_s       g_bus_a;
  type_peri2dbus_s       g_rsp_a;

  // instance B: slave never acks, TIMEOUT_CYC=4
  logic            [1:0] sel_b;
  type_dbus2peri_s [1:0] bus_b;
  type_peri2dbus_s [1:0] rsp_b;
  logic            [1:0] err_b;
  logic                  gsel_b;
  type_dbus2peri_s       g_bus_b;
  type_peri2dbus_s       g_rsp_b;
  assign g_rsp_b = '0;

  gpio_dbus_arb #(.NUM_REQ(2), .TIMEOUT_CYC(255)) u_dut (
    .clk(clk), .rst(rst), .req_sel_i(sel_a), .dbus2arb_i(bus_a),
    .arb2dbus_o(rsp_a), .arb_err_o(err_a), .gpio_sel_o(gsel_a),
    .arb2gpio_o(g_bus_a), .gpio2arb_i(g_rsp_a));

  gpio_dbus_arb #(.NUM_REQ(2), .TIMEOUT_CYC(4)) u_dut_to (
    .clk(clk), .rst(rst), .req_sel_i(sel_b), .dbus2arb_i(bus_b),
    .arb2dbus_o(rsp_b), .arb_err_o(err_b), .gpio_sel_o(gsel_b),
    .arb2gpio_o(g_bus_b), .gpio2arb_i(g_rsp_b));

  logic [7:0] s_dir, s_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_rsp_a <= '0;
      s_dir   <= 8'h0;
      s_data  <= 8'h0;
    end else begin
      g_rsp_a.ack <= 1'b0;
      if (gsel_a && g_bus_a.req && !g_rsp_a.ack) begin
        g_rsp_a.ack    <= 1'b1;
        g_rsp_a.r_data <= {24'h0, g_bus_a.addr[2] ? s_dir : s_data};
        if (g_bus_a.w_en) begin
          if (g_bus_a.addr[2]) s_dir <= g_bus_a.w_data[7:0];
          else                 s_data <= g_bus_a.w_data[7:0];
        end
      end
    end
  end

  int   ack_log[$];
  int   sel_rises = 0;
  logic sel_prev  = 1'b0;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) if (rsp_a[p].ack) ack_log.push_back(p);
    if (gsel_a && !sel_prev) sel_rises++;
    sel_prev = gsel_a;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] d, input logic we);
    bus_a[p].addr = a; bus_a[p].w_data = d; bus_a[p].w_en = we; bus_a[p].req = 1'b1;
    sel_a[p] = 1'b1;
  endtask

  task automatic drop(input int p);
    bus_a[p].req = 1'b0; sel_a[p] = 1'b0;
  endtask

  task automatic do_txn(input int p, input logic [31:0] a, input logic [31:0] d, input logic we,
                        output logic [31:0] rd, output int lat, output logic er,
                        output logic oack, output logic [31:0] ordata);
    int t0;
    @(posedge clk); #1;
    drive(p, a, d, we);
    t0 = cyc; lat = -1; rd = 'x; er = 1'bx; oack = 1'bx; ordata = 'x;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (rsp_a[p].ack) begin
        lat = cyc - t0; rd = rsp_a[p].r_data; er = err_a[p];
        oack = rsp_a[1-p].ack; ordata = rsp_a[1-p].r_data;
      end
    end
    @(posedge clk); #1;
    drop(p);
  endtask

  task automatic both_txn(input logic [31:0] a0, input logic [31:0] d0, input logic we0,
                          input logic [31:0] a1, input logic [31:0] d1, input logic we1,
                          output int lat0, output int lat1,
                          output logic [31:0] rd0, output logic [31:0] rd1);
    int t0;
    @(posedge clk); #1;
    drive(0, a0, d0, we0);
    drive(1, a1, d1, we1);
    t0 = cyc; lat0 = -1; lat1 = -1; rd0 = 'x; rd1 = 'x;
    for (int i = 0; i < 40 && (lat0 < 0 || lat1 < 0); i++) begin
      @(negedge clk);
      if (rsp_a[0].ack && lat0 < 0) begin lat0 = cyc - t0; rd0 = rsp_a[0].r_data; end
      if (rsp_a[1].ack && lat1 < 0) begin lat1 = cyc - t0; rd1 = rsp_a[1].r_data; end
      @(posedge clk); #1;
      if (lat0 >= 0) drop(0);
      if (lat1 >= 0) drop(1);
    end
    drop(0); drop(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] rd, ord, rd0, rd1;
    int          lat, lat0, lat1, t0, t1, p0acks, s0;
    logic        er, oack;

    tbl[0] = '{0, DIR_A,  32'h0000_00A5, 1'b1, 32'h0};
    tbl[1] = '{0, DIR_A,  32'h0,         1'b0, 32'h0000_00A5};
    tbl[2] = '{1, DATA_A, 32'h0000_003C, 1'b1, 32'h0};
    tbl[3] = '{1, DATA_A, 32'h0,         1'b0, 32'h0000_003C};
    tbl[4] = '{0, DATA_A, 32'h0,         1'b0, 32'h0000_003C};
    tbl[5] = '{1, DIR_A,  32'h0,         1'b0, 32'h0000_00A5};

    rst = 1'b1; sel_a = '0; bus_a = '0; sel_b = '0; bus_b = '0;
    idle(2);
    @(negedge clk);
    chk("rst_gsel",  {31'h0, gsel_a}, 32'h0);
    chk("rst_gbus",  {31'h0, |g_bus_a}, 32'h0);
    chk("rst_rsp",   {31'h0, |rsp_a}, 32'h0);
    chk("rst_err",   {30'h0, err_a}, 32'h0);
    chk("rst_b_out", {31'h0, |{gsel_b, g_bus_b, rsp_b, err_b}}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_txn(tbl[v].port, tbl[v].addr, tbl[v].wdata, tbl[v].we, rd, lat, er, oack, ord);
      chk($sformatf("v%0d_lat", v), lat, 3);
      chk($sformatf("v%0d_err", v), {31'h0, er}, 32'h0);
      chk($sformatf("v%0d_oth_ack", v), {31'h0, oack}, 32'h0);
      chk($sformatf("v%0d_oth_rd", v), ord, 32'h0);
      if (!tbl[v].we) chk($sformatf("v%0d_rdata", v), rd, tbl[v].exp_rd);
    end

    // rr_ptr is 0 after tbl[5] (port 1): port 0 wins the tie
    idle(1);
    both_txn(DATA_A, 32'h0F, 1'b1, DIR_A, 32'hFF, 1'b1, lat0, lat1, rd0, rd1);
    chk("sim_lat0", lat0, 3);
    chk("sim_lat1", lat1, 7);
    do_txn(0, DATA_A, 32'h0, 1'b0, rd, lat, er, oack, ord);
    chk("sim_rb_data", rd, 32'h0000_000F);
    do_txn(0, DIR_A, 32'h0, 1'b0, rd, lat, er, oack, ord);
    chk("sim_rb_dir", rd, 32'h0000_00FF);

    // port 0 continuous, port 1 once; rr_ptr is 1 here
    idle(1);
    ack_log.delete();
    @(posedge clk); #1;
    drive(0, DATA_A, 32'h0, 1'b0); t0 = cyc;
    @(posedge clk); #1;
    drive(1, DIR_A, 32'h0, 1'b0); t1 = cyc;
    p0acks = 0; lat1 = -1;
    for (int i = 0; i < 40 && p0acks < 2; i++) begin
      @(negedge clk);
      if (rsp_a[1].ack && lat1 < 0) lat1 = cyc - t1;
      if (rsp_a[0].ack) p0acks++;
      @(posedge clk); #1;
      if (lat1 >= 0) drop(1);
      if (p0acks >= 2) drop(0);
    end
    drop(0); drop(1);
    idle(4);
    chk("rr_nacks", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk("rr_order0", ack_log[0], 0);
      chk("rr_order1", ack_log[1], 1);
      chk("rr_order2", ack_log[2], 0);
    end
    chk("rr_p1_lat", lat1, 6);
    chk("rr_p0_span", cyc - t0 > 11, 1);

    // turnaround: req held one cycle past ack
    ack_log.delete();
    s0 = sel_rises;
    @(posedge clk); #1;
    drive(0, DATA_A, 32'h0, 1'b0); t0 = cyc; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (rsp_a[0].ack) lat = cyc - t0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    drop(0);
    idle(6);
    chk("ta_lat", lat, 3);
    chk("ta_sel_rises", sel_rises - s0, 1);
    chk("ta_acks", ack_log.size(), 1);

    // reset during GRANT after rr_ptr moved to 1
    do_txn(0, DIR_A, 32'h0, 1'b0, rd, lat, er, oack, ord);
    @(posedge clk); #1;
    drive(0, DATA_A, 32'h0, 1'b0);
    @(posedge clk); #2;
    chk("rg_in_grant", {31'h0, gsel_a}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rg_gsel",  {31'h0, gsel_a}, 32'h0);
    chk("rg_gbus",  {31'h0, |g_bus_a}, 32'h0);
    chk("rg_rsp",   {31'h0, |rsp_a}, 32'h0);
    chk("rg_err",   {30'h0, err_a}, 32'h0);
    ack_log.delete();
    @(posedge clk); #1;
    drop(0);
    rst = 1'b0;
    idle(5);
    chk("rg_no_ack", ack_log.size(), 0);
    both_txn(DATA_A, 32'h0, 1'b0, DIR_A, 32'h0, 1'b0, lat0, lat1, rd0, rd1);
    chk("rg_lat0", lat0, 3);
    chk("rg_lat1", lat1, 7);

    // timeout on instance B
    @(posedge clk); #1;
    bus_b[0].addr = DIR_A; bus_b[0].w_data = '0; bus_b[0].w_en = 1'b0; bus_b[0].req = 1'b1;
    sel_b[0] = 1'b1;
    t0 = cyc; lat = -1; rd = 'x; er = 1'bx; oack = 1'bx;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (cyc == t0 + 1) chk("to_sel_grant", {31'h0, gsel_b}, 32'h1);
      if (rsp_b[0].ack) begin
        lat = cyc - t0; rd = rsp_b[0].r_data; er = err_b[0]; oack = err_b[1];
      end
    end
    @(posedge clk); #1;
    bus_b[0].req = 1'b0; sel_b[0] = 1'b0;
    chk("to_lat", lat, 6);
    chk("to_rdata", rd, 32'h0);
    chk("to_err", {31'h0, er}, 32'h1);
    chk("to_err_oth", {31'h0, oack}, 32'h0);
    @(negedge clk);
    chk("to_idle", {31'h0, |{gsel_b, g_bus_b, rsp_b, err_b}}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
